// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL timer block.
// JTOPL_FASTTIMER_EN shortens the prescaler so Timer A ticks once per sample.
package jtopl_pkg;

`ifdef JTOPL_FASTTIMER_EN
    localparam logic [6:0] JTOPL_PRESCALE_A = 7'd17;
`else
    localparam logic [6:0] JTOPL_PRESCALE_A = 7'd71;
`endif

    localparam int         JTOPL_B_DIV  = 4;
    localparam logic [1:0] JTOPL_B_LAST = 2'(JTOPL_B_DIV - 1);

    localparam int JTOPL_ST_IRQ    = 7;
    localparam int JTOPL_ST_FLAG_A = 6;
    localparam int JTOPL_ST_FLAG_B = 5;

    function automatic logic [7:0] jtopl_status(input logic irq, input logic fa, input logic fb);
        logic [7:0] s;
        s                  = 8'h00;
        s[JTOPL_ST_IRQ]    = irq;
        s[JTOPL_ST_FLAG_A] = fa;
        s[JTOPL_ST_FLAG_B] = fb;
        return s;
    endfunction

endpackage

// File: rtl/jtopl_timer.sv
// One OPL timer: 8-bit up-counter with start edge detect, reload on overflow
// and a latched overflow flag.
module jtopl_timer
    import jtopl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cenop,
    input  logic       tick,
    input  logic       load,
    input  logic       flagen,
    input  logic       clr_flag,
    input  logic [7:0] value,
    output logic       flag,
    output logic       overflow
);

    logic [7:0] cnt_r;
    logic       load_r;
    logic       flag_r;
    logic       start_s;
    logic       overflow_s;

    // A start outranks a coinciding tick, so counting begins at the next tick.
    assign start_s    = cenop & load & ~load_r;
    assign overflow_s = tick & load & load_r & (cnt_r == 8'hFF);

    // Load level sampled on cenop for start edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_r <= 1'b0;
        end else if (cenop) begin
            load_r <= load;
        end
    end

    // Counter: preset on start, reload on overflow, otherwise step on tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'h00;
        end else if (start_s || overflow_s) begin
            cnt_r <= value;
        end else if (tick && load) begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    // Overflow flag; a set on the same edge as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_r <= 1'b0;
        end else if (overflow_s && flagen) begin
            flag_r <= 1'b1;
        end else if (clr_flag) begin
            flag_r <= 1'b0;
        end
    end

    assign flag     = flag_r;
    assign overflow = overflow_s;

endmodule

// File: rtl/jtopl_timers.sv
// OPL Timer A/B pair with shared prescaler and interrupt/status generation.
// Define JTOPL_FASTTIMER_EN for a shortened simulation-only prescaler.
module jtopl_timers
    import jtopl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cenop,
    input  logic [7:0] value_A,
    input  logic [7:0] value_B,
    input  logic       load_A,
    input  logic       load_B,
    input  logic       flagen_A,
    input  logic       flagen_B,
    input  logic       clr_flag_A,
    input  logic       clr_flag_B,
    output logic       flag_A,
    output logic       flag_B,
    output logic       overflow_A,
    output logic       irq_n,
    output logic [7:0] status
);

    logic [6:0] pre_r;
    logic [1:0] sub_r;
    logic       irq_n_r;
    logic       tick_a_s;
    logic       tick_b_s;

    assign tick_a_s = cenop & (pre_r == JTOPL_PRESCALE_A);
    assign tick_b_s = tick_a_s & (sub_r == JTOPL_B_LAST);

    // Free-running prescaler; independent of the timer load bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= 7'd0;
        end else if (cenop) begin
            pre_r <= tick_a_s ? 7'd0 : pre_r + 7'd1;
        end
    end

    // Timer B divider, stepped by Timer A ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_r <= 2'd0;
        end else if (tick_a_s) begin
            sub_r <= sub_r + 2'd1;
        end
    end

    // Interrupt follows the latched flags by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_n_r <= 1'b1;
        end else begin
            irq_n_r <= ~(flag_A | flag_B);
        end
    end

    jtopl_timer u_timer_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .cenop    (cenop),
        .tick     (tick_a_s),
        .load     (load_A),
        .flagen   (flagen_A),
        .clr_flag (clr_flag_A),
        .value    (value_A),
        .flag     (flag_A),
        .overflow (overflow_A)
    );

    jtopl_timer u_timer_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .cenop    (cenop),
        .tick     (tick_b_s),
        .load     (load_B),
        .flagen   (flagen_B),
        .clr_flag (clr_flag_B),
        .value    (value_B),
        .flag     (flag_B),
        .overflow ()
    );

    assign irq_n  = irq_n_r;
    assign status = jtopl_status(~irq_n_r, flag_A, flag_B);

endmodule

// File: tb/tb_jtopl_timers.sv
// Directed + randomized-cenop bench for jtopl_timers against a cenop-count
// based reference model.
module tb_jtopl_timers;
    import jtopl_pkg::*;

    localparam int PA = int'(JTOPL_PRESCALE_A) + 1;
    localparam int PB = PA * JTOPL_B_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cenop = 1'b0;
    logic [7:0] value_A = 8'h00;
    logic [7:0] value_B = 8'h00;
    logic       load_A = 1'b0, load_B = 1'b0;
    logic       flagen_A = 1'b0, flagen_B = 1'b0;
    logic       clr_flag_A = 1'b0, clr_flag_B = 1'b0;
    logic       flag_A, flag_B, overflow_A, irq_n;
    logic [7:0] status;

    jtopl_timers dut (
        .clk(clk), .rst_n(rst_n), .cenop(cenop),
        .value_A(value_A), .value_B(value_B),
        .load_A(load_A), .load_B(load_B),
        .flagen_A(flagen_A), .flagen_B(flagen_B),
        .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
        .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
        .irq_n(irq_n), .status(status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: timing derived from the number of cenops since reset.
    int m_cens;
    int m_cnt[2];
    bit m_loadr[2];
    bit m_flag[2];
    bit m_irqn;
    int n_ovf, last_ovf, ovf_gap, first_ovf;
    int guard, t0;
    bit cen;

    function automatic bit m_tick(int i, bit c);
        if (!c) return 1'b0;
        if (i == 0) return (m_cens % PA) == PA - 1;
        return (m_cens % PB) == PB - 1;
    endfunction

    function automatic bit m_ovf(int i, bit c, bit ld);
        return m_tick(i, c) && ld && m_loadr[i] && (m_cnt[i] == 255);
    endfunction

    task automatic model_reset();
        m_cens = 0;
        m_cnt = '{0, 0};
        m_loadr = '{1'b0, 1'b0};
        m_flag = '{1'b0, 1'b0};
        m_irqn = 1'b1;
        first_ovf = -1;
    endtask

    task automatic model_edge();
        bit ld[2], fe[2], cl[2], ov[2];
        int val[2];
        ld = '{load_A, load_B};
        fe = '{flagen_A, flagen_B};
        cl = '{clr_flag_A, clr_flag_B};
        val = '{int'(value_A), int'(value_B)};
        m_irqn = !(m_flag[0] || m_flag[1]);
        for (int i = 0; i < 2; i++) begin
            ov[i] = m_ovf(i, cenop, ld[i]);
            if (cenop) begin
                if (ld[i] && !m_loadr[i]) m_cnt[i] = val[i];
                else if (m_tick(i, 1'b1) && ld[i]) m_cnt[i] = ov[i] ? val[i] : m_cnt[i] + 1;
                m_loadr[i] = ld[i];
            end
            if (ov[i] && fe[i]) m_flag[i] = 1'b1;
            else if (cl[i]) m_flag[i] = 1'b0;
        end
        if (cenop) m_cens++;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_ovf"}, 32'(overflow_A), 32'h0);
        chk({tag, "_flag_A"}, 32'(flag_A), 32'h0);
        chk({tag, "_flag_B"}, 32'(flag_B), 32'h0);
        chk({tag, "_irq_n"}, 32'(irq_n), 32'h1);
        chk({tag, "_status"}, 32'(status), 32'h00);
    endtask

    // One clk cycle: overflow_A checked mid-cycle, registered outputs after the edge.
    task automatic cycle(input bit c);
        cenop = c;
        @(negedge clk);
        chk("overflow_A", 32'(overflow_A), 32'(rst_n && m_ovf(0, c, load_A)));
        if (overflow_A === 1'b1) begin
            n_ovf++;
            ovf_gap = m_cens - last_ovf;
            last_ovf = m_cens;
            if (first_ovf < 0) first_ovf = m_cens;
        end
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        chk("flag_A", 32'(flag_A), 32'(m_flag[0]));
        chk("flag_B", 32'(flag_B), 32'(m_flag[1]));
        chk("irq_n", 32'(irq_n), 32'(m_irqn));
        chk("status", 32'(status), {24'h0, ~m_irqn, m_flag[0], m_flag[1], 5'b0});
    endtask

    function automatic bit rnd_cen();
        return $urandom_range(0, 2) != 0;
    endfunction

    initial begin
        model_reset();
        n_ovf = 0; last_ovf = 0; ovf_gap = 0;
        #2 rst_n = 1'b0;
        #1 chk_reset("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Timer A at FE: overflow every two ticks, flag raises the interrupt
        value_A = 8'hFE; load_A = 1'b1; flagen_A = 1'b1;
        guard = 0;
        while (n_ovf < 2 && guard < 5000) begin cycle(rnd_cen()); guard++; end
        chk("a_two_ovf", 32'(n_ovf), 32'd2);
        chk("a_first_ovf_cens", 32'(first_ovf), 32'(2 * PA - 1));
        chk("a_ovf_period", 32'(ovf_gap), 32'(2 * PA));
        chk("a_flag_set", 32'(flag_A), 32'h1);
        chk("a_irq_low", 32'(irq_n), 32'h0);
        chk("a_status_c0", 32'(status), 32'hC0);

        // Flag disabled, preset changed mid-run: strobe continues, no flag
        clr_flag_A = 1'b1; cycle(1'b0); clr_flag_A = 1'b0;
        flagen_A = 1'b0;
        value_A = 8'($urandom_range(8'hF8, 8'hFE));
        n_ovf = 0; guard = 0;
        while (n_ovf < 3 && guard < 20000) begin cycle(rnd_cen()); guard++; end
        chk("noflag_ovf_seen", 32'(n_ovf), 32'd3);
        chk("noflag_flag_A", 32'(flag_A), 32'h0);
        chk("noflag_irq_n", 32'(irq_n), 32'h1);

        // Timer B at FF: flag every tickB
        load_A = 1'b0; value_B = 8'hFF; load_B = 1'b1; flagen_B = 1'b1;
        guard = 0;
        while (flag_B !== 1'b1 && guard < 5000) begin cycle(rnd_cen()); guard++; end
        t0 = m_cens;
        cycle(1'b0);
        chk("b_status_a0", 32'(status), 32'hA0);
        clr_flag_B = 1'b1; cycle(1'b0); clr_flag_B = 1'b0;
        guard = 0;
        while (flag_B !== 1'b1 && guard < 5000) begin cycle(rnd_cen()); guard++; end
        chk("b_flag_period", 32'(m_cens - t0), 32'(PB));

        // Clear on the same edge as an A overflow: set wins
        value_A = 8'hFE; flagen_A = 1'b1; load_A = 1'b1;
        guard = 0;
        while (guard < 5000) begin
            cen = rnd_cen();
            clr_flag_A = m_ovf(0, cen, load_A);
            cycle(cen);
            guard++;
            if (clr_flag_A) break;
        end
        clr_flag_A = 1'b0;
        chk("set_wins_flag_A", 32'(flag_A), 32'h1);
        clr_flag_A = 1'b1; cycle(1'b0); clr_flag_A = 1'b0;
        chk("clr_alone_flag_A", 32'(flag_A), 32'h0);

        // Halt at cnt 80, hold, then restart from the new preset
        load_A = 1'b0; cycle(1'b1);
        value_A = 8'h70; load_A = 1'b1;
        guard = 0;
        while (m_cnt[0] != 8'h80 && guard < 10000) begin cycle(rnd_cen()); guard++; end
        chk("cnt_reached_80", 32'(dut.u_timer_a.cnt_r), 32'h80);
        load_A = 1'b0; value_A = 8'h33;
        for (int i = 0; i < 300; i++) cycle(rnd_cen());
        chk("cnt_held_80", 32'(dut.u_timer_a.cnt_r), 32'h80);
        load_A = 1'b1; cycle(1'b1);
        chk("cnt_restart_33", 32'(dut.u_timer_a.cnt_r), 32'h33);

        // Both flags set, then asynchronous reset between edges
        load_A = 1'b0; cycle(1'b1);
        value_A = 8'hFE; load_A = 1'b1;
        guard = 0;
        while (!(flag_A === 1'b1 && flag_B === 1'b1) && guard < 5000) begin cycle(rnd_cen()); guard++; end
        chk("both_flags_set", {30'h0, flag_A, flag_B}, 32'h3);
        #2 rst_n = 1'b0;
        #1 chk_reset("async_rst");
        model_reset();
        cycle(1'b1); cycle(1'b1);
        rst_n = 1'b1;
        n_ovf = 0; guard = 0;
        while (n_ovf < 1 && guard < 5000) begin cycle(rnd_cen()); guard++; end
        chk("prescaler_restart", 32'(first_ovf), 32'(2 * PA - 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtopl_timers.md
JTOPL_TIMERS -- requirements
Module: jtopl_timers

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The ports SHALL be as follows:
- clk  in  1  master clock
- rst_n  in  1  asynchronous active-low reset
- cenop  in  1  operator-slot clock enable; 18 pulses per sample
- value_A  in  8  Timer A preset
- value_B  in  8  Timer B preset
- load_A, load_B  in  1 each  level; 1 = run, 0 = halt
- flagen_A, flagen_B  in  1 each  1 = overflow may set the flag
- clr_flag_A, clr_flag_B  in  1 each  flag clear request
- flag_A, flag_B  out  1 each  latched overflow flags
- overflow_A  out  1  Timer A overflow strobe, for CSM key-on
- irq_n  out  1  active-low interrupt
- status  out  8  {irq, flag_A, flag_B, 5'b0}

Function
REQ-003 Prescaler: a free-running counter SHALL count cenop pulses 0..71 and wrap; tickA SHALL assert on the cenop at which the count is 71 (one tick per 80 us).
REQ-004 A 2-bit counter SHALL advance on each tickA; tickB SHALL be tickA AND counter==3 (one tick per 320 us).
REQ-005 The prescaler SHALL run regardless of the load bits and SHALL never be reset by a load.
REQ-006 Each timer SHALL hold an 8-bit up-counter cnt.
REQ-007 Start: on a cenop where load goes 0->1, measured against a registered copy of load sampled on cenop, cnt SHALL be set to value; counting begins at the next tick.
REQ-008 On a tick with load=1 and cnt!=8'hFF, cnt SHALL increment by 1.
REQ-009 On a tick with load=1 and cnt==8'hFF, cnt SHALL reload value (not 0) and an overflow event SHALL occur.
REQ-010 Hence the period SHALL be (256 - value) ticks.
REQ-011 With load=0, cnt SHALL hold its value and no overflow SHALL occur.
REQ-012 A value change while running SHALL take effect only at the next reload or start.
REQ-013 overflow_A SHALL be high for exactly one clk cycle: the cycle of the cenop carrying the Timer A overflow event. It SHALL assert regardless of flagen_A.
REQ-014 Flag set: an overflow event with flagen=1 SHALL set the flag on that same clk edge.
REQ-015 With flagen=0, the flag SHALL be unchanged by overflow.
REQ-016 Flag clear: clr_flag=1 on any clk edge (no cenop gating) SHALL clear the flag.
REQ-017 If set and clear occur on the same edge, set SHALL win.
REQ-018 irq_n SHALL equal ~(flag_A | flag_B), registered; status[7] SHALL equal ~irq_n.
REQ-019 A Timer B overflow that coincides with a Timer A overflow SHALL be handled independently; no event SHALL be lost.

Reset
REQ-020 While rst_n=0, all of the following SHALL be cleared immediately and asynchronously: prescaler, B sub-counter, cnt A/B, registered load copies, flags, overflow_A=0, irq_n=1, status=8'h00.
REQ-021 Reset deassertion mid-period SHALL restart the prescaler from 0.

Configuration
REQ-022 Macro JTOPL_FASTTIMER_EN SHALL select the prescaler length.
- Defined: the prescaler SHALL wrap at 17, giving tickA once per sample and tickB every 4 samples. This is for simulation only.
- Undefined: the prescaler SHALL wrap at 71, as in REQ-003.
- All other behaviour SHALL be identical in both builds.

Structure
REQ-023 Package jtopl_pkg SHALL hold the constants JTOPL_PRESCALE_A (71 or 17), JTOPL_B_DIV (4) and the status bit positions.
REQ-024 One sub-module, jtopl_timer, SHALL implement cnt, the start edge, reload, overflow and flag logic. It SHALL be instantiated twice, driven by tickA and tickB; the prescaler SHALL live in the top.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- value_A=8'hFE, load_A=1, flagen_A=1 -> overflow_A pulses every 2 tickA (144 cenop); flag_A=1; irq_n=0; status=8'hC0.
- Repeat with flagen_A=0 -> overflow_A still pulses; flag_A stays 0; irq_n stays 1.
- value_B=8'hFF, load_B=1 -> flag_B sets every tickB (288 cenop); status=8'hA0.
- clr_flag_A asserted on the same edge as an A overflow -> flag_A remains 1; next clr_flag_A alone -> flag_A=0.
- load_A toggled 1->0 mid-count at cnt=8'h80 -> cnt holds 8'h80; 0->1 -> cnt reloads value_A.
- rst_n pulsed low between cenops while both flags are set -> all outputs at reset values that same cycle; prescaler restarts at 0.
